// File: rtl/prio_decoder_stretch.sv
// Priority-code to one-hot request decoder with a programmable pulse stretch.
// A legal code 1..4 drives r_out_o[code] for hold_len+1 cycles; illegal codes set a sticky error.
module prio_decoder_stretch #(
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        code_i,
   input  logic [HOLD_W-1:0] hold_len_i,
   output logic [4:1]        r_out_o,
   output logic              busy_o,
   output logic              err_o,
   input  logic              err_clr_i
);

   // state | meaning
   // IDLE  | no request driven, always ready for a code
   // HOLD  | one request line driven; ready only when the counter reaches zero
   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q;
   logic [HOLD_W-1:0] cnt_q;
   logic [4:1]        r_out_q;
   logic              busy_q;
   logic              err_q;

   logic [4:1]        onehot_d;
   logic              accept;
   logic              legal_nz;
   logic              illegal;
   logic              final_cyc;

   always_comb begin
      onehot_d = 4'b0000;
      case (code_i)
         3'd1:    onehot_d = 4'b0001;
         3'd2:    onehot_d = 4'b0010;
         3'd3:    onehot_d = 4'b0100;
         3'd4:    onehot_d = 4'b1000;
         default: onehot_d = 4'b0000;
      endcase
   end

   assign legal_nz  = |onehot_d;
   assign illegal   = (code_i > 3'd4);
   assign final_cyc = (state_q == IDLE) || (cnt_q == '0);
   // Gated by reset_n so the source never sees ready while the block is held in reset.
   assign in_ready_o = reset_n && final_cyc;
   assign accept     = in_valid_i && in_ready_o;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_out_q <= 4'b0000;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // Set beats clear when both happen in the same cycle.
         if (accept && illegal)
            err_q <= 1'b1;
         else if (err_clr_i)
            err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (accept && legal_nz) begin
                  state_q <= HOLD;
                  r_out_q <= onehot_d;
                  cnt_q   <= hold_len_i;
                  busy_q  <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (accept && legal_nz) begin
                  r_out_q <= onehot_d;
                  cnt_q   <= hold_len_i;
               end else begin
                  state_q <= IDLE;
                  r_out_q <= 4'b0000;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               r_out_q <= 4'b0000;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign r_out_o = r_out_q;
   assign busy_o  = busy_q;
   assign err_o   = err_q;

endmodule

// File: doc/prio_decoder_stretch.md
Name: prio_decoder_stretch

Overview:
- Inverse of the 4-request priority encoder: accepts a 3-bit priority code (0 = none, 1..4 = request line index) over a valid/ready handshake and regenerates a one-hot request vector r_out[4:1].
- Each decoded request is held for a programmable number of cycles (pulse stretch). This lets a downstream block that re-encodes r_out, or drives LEDs or strobes, see a stable request.
- Sits between a code source (encoder or register interface) and one-hot request consumers.

Parameters:
- HOLD_W, 8, width of the hold_len input and of the internal hold down-counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, code is presented this cycle.
- in_ready, output, 1, block can accept a code this cycle.
- code, input, 3, priority code: 3'b000 none, 3'b001..3'b100 select r_out[1]..r_out[4], 3'b101..3'b111 illegal.
- hold_len, input, HOLD_W, extra hold cycles; sampled only at acceptance.
- r_out, output, 4 (bits 4:1), registered one-hot request vector.
- busy, output, 1, high while r_out is nonzero (HOLD state).
- err, output, 1, sticky flag set on acceptance of an illegal code.
- err_clr, input, 1, synchronous clear of err.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, r_out=4'b0000, busy=0, err=0, hold counter=0. in_ready=0 while reset_n=0. In IDLE, in_ready=1 from the first cycle after release.
- Clock and reset naming, polarity and synchronicity are fixed: one clock clk; reset_n asynchronous, active-low.
- Accept occurs in cycle n when in_valid && in_ready. code and hold_len are sampled at that edge.
- State IDLE:
  - in_ready=1, r_out=0.
  - Accept legal nonzero code c → HOLD. r_out = one-hot bit c from cycle n+1. Counter loaded with sampled hold_len.
  - Accept code 0 → no-op, stay IDLE, r_out stays 0.
  - Accept illegal code → stay IDLE, err=1 from cycle n+1, r_out stays 0.
- State HOLD:
  - r_out held constant; busy=1. Counter decrements each cycle while nonzero.
  - in_ready=1 only in the final hold cycle (counter==0), otherwise 0.
- HOLD exit:
  - Final cycle with no accept → IDLE next cycle, r_out=0.
  - Final cycle with accept of a legal nonzero code → r_out switches directly to the new one-hot with no zero gap; counter reloads; stays HOLD.
  - Final cycle with accept of code 0 or an illegal code → IDLE, r_out=0. err rules as in IDLE.
- Latency: r_out asserted for exactly hold_len+1 cycles, cycles n+1 .. n+1+hold_len. hold_len=0 gives a single-cycle pulse with in_ready=1 in every cycle, i.e. back-to-back throughput of 1 code/cycle.
- hold_len is ignored outside acceptance; changing it mid-hold has no effect.
- err_clr=1 clears err next cycle. Simultaneous err_clr and illegal-code accept: set wins (err=1).
- in_valid while in_ready=0: no effect; the source must hold code stable until accepted (standard valid/ready).
- Invariant: r_out is always zero or exactly one-hot, and never multi-hot.
- Mid-operation reset: r_out goes to 0 and err clears asynchronously; the in-flight hold is discarded.
- Counter max: hold_len = 2^HOLD_W-1 holds 2^HOLD_W cycles; no wrap-around.

Test Plan:
- Reset then code=3'b011, hold_len=2, one-cycle valid → r_out=4'b0100 for exactly 3 cycles, busy=1 for those 3 cycles, in_ready=0 for the first 2 of them, then IDLE with r_out=0.
- hold_len=0, codes 1,2,3,4 on consecutive cycles → in_ready stays 1; r_out = 0001,0010,0100,1000 on the following consecutive cycles; no zero gap.
- code=3'b110 accepted → err=1 next cycle, r_out=0. err_clr pulse → err=0. Illegal code accepted with err_clr=1 in the same cycle → err stays 1.
- code=3'b100, hold_len=5; in_valid held high with code=3'b001 throughout → second code accepted only in the 6th hold cycle; r_out goes from 1000 directly to 0001.
- code=3'b000 accepted → r_out stays 0, busy stays 0, in_ready stays 1.
- reset_n pulled low mid-hold (hold_len=10, cycle 4) → r_out=0, busy=0, err=0 immediately. After release the block is in IDLE with in_ready=1.
